// File: rtl/md5_core_ctrl_if.sv
// Start-slot bus between md5_core_ctrl (master) and the MD5 core array (slave).
// Carries frame_cnt only when CORE_CTRL_FRAME_CNT_EN is defined.
interface md5_core_ctrl_if #(
  parameter int N_CORES = 3
);
  logic [N_CORES-1:0] core_start;
  logic               ctx_num;
  logic [N_CORES-1:0] seq_num;
`ifdef CORE_CTRL_FRAME_CNT_EN
  logic [31:0]        frame_cnt;
`endif

  modport master (
    output core_start,
    output ctx_num,
`ifdef CORE_CTRL_FRAME_CNT_EN
    output frame_cnt,
`endif
    output seq_num
  );

  modport slave (
    input core_start,
    input ctx_num,
`ifdef CORE_CTRL_FRAME_CNT_EN
    input frame_cnt,
`endif
    input seq_num
  );
endinterface

// File: rtl/md5_core_ctrl.sv
// Free-running staggered start scheduler for N_CORES two-context MD5 cores.
// Optional full-frame counter output enabled by defining CORE_CTRL_FRAME_CNT_EN.
module md5_core_ctrl #(
  parameter int N_CORES  = 3,
  parameter int SLOT     = 4,
  parameter int HALF_LEN = 18
) (
  input  logic CLK,
  input  logic reset,
  md5_core_ctrl_if.master bus
);

  localparam int             PW   = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
  localparam logic [PW-1:0]  LAST = PW'(HALF_LEN - 1);

  // Reject schedules where core starts would spill into the next half-frame.
  generate
    if (N_CORES < 1 || N_CORES > 16 || SLOT < 1 || N_CORES * SLOT > HALF_LEN) begin : g_cfg_check
      $error("md5_core_ctrl: invalid N_CORES/SLOT/HALF_LEN combination");
    end
  endgenerate

  logic [PW-1:0]            r_phase;
  logic                     r_ctx;
  logic [1:0][N_CORES-1:0]  r_seq;
  logic [N_CORES-1:0]       w_hit;
  logic                     w_last;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_hit[i] = (r_phase == PW'(i * SLOT));
    end
  end

  assign w_last = (r_phase == LAST);

  // NOTE: non-blocking assignments make every output and state update use the
  // pre-edge values of r_phase/r_ctx/r_seq, which is what the schedule relies on.
  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: the seq array is a handful of flops and must start from zero so
      // the first start of each (core, ctx) carries sequence bit 0; reset it.
      r_phase        <= '0;
      r_ctx          <= 1'b0;
      r_seq          <= '0;
      bus.core_start <= '0;
      bus.ctx_num    <= 1'b0;
      bus.seq_num    <= '0;
`ifdef CORE_CTRL_FRAME_CNT_EN
      bus.frame_cnt  <= '0;
`endif
    end else begin
      bus.core_start <= w_hit;
      bus.ctx_num    <= r_ctx;
      bus.seq_num    <= r_seq[r_ctx];
      // The pulse carries the old bit; the next start of this (core, ctx) sees it inverted.
      r_seq[r_ctx]   <= r_seq[r_ctx] ^ w_hit;
      if (w_last) begin
        r_phase <= '0;
        r_ctx   <= ~r_ctx;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
`ifdef CORE_CTRL_FRAME_CNT_EN
      if (w_last && r_ctx) begin
        bus.frame_cnt <= bus.frame_cnt + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_md5_core_ctrl.sv
// Directed bench for md5_core_ctrl: default configuration plus the
// N_CORES=4/SLOT=1/HALF_LEN=4 corner, driven from a shared clock and reset.
module tb_md5_core_ctrl;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  md5_core_ctrl_if #(.N_CORES(3)) bus_a ();
  md5_core_ctrl_if #(.N_CORES(4)) bus_c ();

  md5_core_ctrl #(.N_CORES(3), .SLOT(4), .HALF_LEN(18)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus_a.master)
  );

  md5_core_ctrl #(.N_CORES(4), .SLOT(1), .HALF_LEN(4)) dut_c (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus_c.master)
  );

  // Holds reset for n edges, checking that every output is zero after each.
  task automatic test_reset(input int n);
    reset = 1'b1;
    for (int e = 0; e < n; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      n_vec++;
      if (bus_a.core_start !== 3'b000 || bus_a.ctx_num !== 1'b0 || bus_a.seq_num !== 3'b000) begin
        n_err++;
        $display("FAIL reset_a edge %0d: start=%b ctx=%b seq=%b required all 0",
                 e, bus_a.core_start, bus_a.ctx_num, bus_a.seq_num);
      end
      n_vec++;
      if (bus_c.core_start !== 4'b0000 || bus_c.ctx_num !== 1'b0 || bus_c.seq_num !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_c edge %0d: start=%b ctx=%b seq=%b required all 0",
                 e, bus_c.core_start, bus_c.ctx_num, bus_c.seq_num);
      end
`ifdef CORE_CTRL_FRAME_CNT_EN
      n_vec++;
      if (bus_a.frame_cnt !== 32'd0) begin
        n_err++;
        $display("FAIL reset_frame_cnt edge %0d: got %0d required 0", e, bus_a.frame_cnt);
      end
`endif
    end
  endtask

  // Releases reset and checks the schedule for edges T0..T0+n-1 against the
  // hand-derived pattern. Reset is left low on return.
  task automatic test_schedule(input int n);
    logic [2:0] exp_a;
    logic [3:0] exp_c;
    logic       exp_ctx_a, exp_ctx_c, exp_seq_a, exp_seq_c;
    int         ph;
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      // Default build: starts at phases 0, 4, 8 of an 18-cycle half-frame.
      ph        = k % 18;
      exp_a     = (ph == 0) ? 3'b001 : (ph == 4) ? 3'b010 : (ph == 8) ? 3'b100 : 3'b000;
      exp_ctx_a = ((k / 18) % 2) == 1;
      exp_seq_a = ((k / 36) % 2) == 1;
      n_vec++;
      if (bus_a.core_start !== exp_a) begin
        n_err++;
        $display("FAIL start_a T0+%0d: got %b required %b", k, bus_a.core_start, exp_a);
      end
      n_vec++;
      if (bus_a.ctx_num !== exp_ctx_a) begin
        n_err++;
        $display("FAIL ctx_a T0+%0d: got %b required %b", k, bus_a.ctx_num, exp_ctx_a);
      end
      for (int i = 0; i < 3; i++) begin
        if (exp_a[i]) begin
          n_vec++;
          if (bus_a.seq_num[i] !== exp_seq_a) begin
            n_err++;
            $display("FAIL seq_a[%0d] T0+%0d: got %b required %b", i, k, bus_a.seq_num[i], exp_seq_a);
          end
        end
      end
`ifdef CORE_CTRL_FRAME_CNT_EN
      n_vec++;
      if (bus_a.frame_cnt !== 32'((k + 1) / 36)) begin
        n_err++;
        $display("FAIL frame_cnt T0+%0d: got %0d required %0d", k, bus_a.frame_cnt, (k + 1) / 36);
      end
`endif
      // Corner build: one start per cycle, ctx flips every 4 cycles.
      exp_c     = 4'b0001 << (k % 4);
      exp_ctx_c = ((k / 4) % 2) == 1;
      exp_seq_c = ((k / 8) % 2) == 1;
      n_vec++;
      if (bus_c.core_start !== exp_c) begin
        n_err++;
        $display("FAIL start_c T0+%0d: got %b required %b", k, bus_c.core_start, exp_c);
      end
      n_vec++;
      if (bus_c.ctx_num !== exp_ctx_c) begin
        n_err++;
        $display("FAIL ctx_c T0+%0d: got %b required %b", k, bus_c.ctx_num, exp_ctx_c);
      end
      n_vec++;
      if (bus_c.seq_num[k % 4] !== exp_seq_c) begin
        n_err++;
        $display("FAIL seq_c[%0d] T0+%0d: got %b required %b", k % 4, k, bus_c.seq_num[k % 4], exp_seq_c);
      end
    end
  endtask

  // Runs into the first half-frame, aborts it with a 3-edge reset, then
  // expects the schedule to restart from phase 0, ctx 0, all seq bits 0.
  task automatic test_mid_reset();
    test_schedule(6);
    test_reset(3);
    test_schedule(40);
  endtask

  initial begin
    test_reset(3);
    test_schedule(90);
    test_reset(2);
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
